// File: rtl/serdes_eye_select.sv
// rtl/serdes_eye_select.sv - widest lock-window search over per-slip delay-tap masks
// Define SERDES_EYE_WINDOW_EN to add the window_len_out port.
module serdes_eye_select #(
  parameter int    NUM_SLIP   = 12,
  parameter int    MIN_WINDOW = 4,
  parameter string DEBUG      = "FALSE"
) (
  input  logic        px_clk,
  input  logic        px_reset_n,
  input  logic [31:0] lock_mask_din,
  input  logic [3:0]  lock_mask_waddr,
  input  logic        lock_mask_we,
  input  logic        start,
  output logic        busy_out,
  output logic [7:0]  delay_sel_out,
  output logic [7:0]  slip_sel_out,
  output logic        lock_ok_out,
  output logic        done_out
`ifdef SERDES_EYE_WINDOW_EN
  ,
  output logic [5:0]  window_len_out
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SCAN   = 3'd2,
    ST_NEXT   = 3'd3,
    ST_RESULT = 3'd4
  } state_t;

  localparam logic [4:0] NUM_SLIP_W = 5'(NUM_SLIP);
  localparam logic [3:0] LAST_SLIP  = 4'(NUM_SLIP - 1);
  localparam logic [5:0] MIN_LEN    = 6'(MIN_WINDOW);

  state_t      state_q, state_d;
  logic [31:0] table_q [NUM_SLIP];
  logic [31:0] mask_q, mask_d;
  logic [3:0]  s_q, s_d;
  logic [4:0]  d_q, d_d;
  logic [5:0]  cur_len_q, cur_len_d;
  logic [4:0]  cur_start_q, cur_start_d;
  logic [5:0]  best_len_q, best_len_d;
  logic [4:0]  best_start_q, best_start_d;
  logic [3:0]  best_slip_q, best_slip_d;
  logic [7:0]  delay_sel_q, delay_sel_d;
  logic [7:0]  slip_sel_q, slip_sel_d;
  logic        lock_ok_q, lock_ok_d;
  logic        done_q, done_d;

  logic        tbl_we;
  logic [5:0]  run_len;
  logic [4:0]  run_start;
  logic [5:0]  centre;

  if (DEBUG == "TRUE") begin : g_debug
  end

  // The table is frozen for the whole scan so results reflect one consistent snapshot.
  assign tbl_we = lock_mask_we && (state_q == ST_IDLE) && ({1'b0, lock_mask_waddr} < NUM_SLIP_W);

  always_ff @(posedge px_clk or negedge px_reset_n) begin
    if (!px_reset_n) begin
      for (int i = 0; i < NUM_SLIP; i++) begin
        table_q[i] <= '0;
      end
    end else if (tbl_we) begin
      table_q[lock_mask_waddr] <= lock_mask_din;
    end
  end

  always_ff @(posedge px_clk or negedge px_reset_n) begin
    if (!px_reset_n) begin
      state_q      <= ST_IDLE;
      mask_q       <= '0;
      s_q          <= '0;
      d_q          <= '0;
      cur_len_q    <= '0;
      cur_start_q  <= '0;
      best_len_q   <= '0;
      best_start_q <= '0;
      best_slip_q  <= '0;
      delay_sel_q  <= '0;
      slip_sel_q   <= '0;
      lock_ok_q    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      s_q          <= s_d;
      d_q          <= d_d;
      cur_len_q    <= cur_len_d;
      cur_start_q  <= cur_start_d;
      best_len_q   <= best_len_d;
      best_start_q <= best_start_d;
      best_slip_q  <= best_slip_d;
      delay_sel_q  <= delay_sel_d;
      slip_sel_q   <= slip_sel_d;
      lock_ok_q    <= lock_ok_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    s_d          = s_q;
    d_d          = d_q;
    cur_len_d    = cur_len_q;
    cur_start_d  = cur_start_q;
    best_len_d   = best_len_q;
    best_start_d = best_start_q;
    best_slip_d  = best_slip_q;
    delay_sel_d  = delay_sel_q;
    slip_sel_d   = slip_sel_q;
    lock_ok_d    = lock_ok_q;
    done_d       = 1'b0;
    run_len      = cur_len_q + 6'd1;
    run_start    = (cur_len_q == 6'd0) ? d_q : cur_start_q;
    centre       = {1'b0, best_start_q} + {1'b0, best_len_q[5:1]};

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          best_len_d   = '0;
          best_start_d = '0;
          best_slip_d  = '0;
          s_d          = '0;
          state_d      = ST_LOAD;
        end
      end
      ST_LOAD: begin
        mask_d    = table_q[s_q];
        d_d       = '0;
        cur_len_d = '0;
        state_d   = ST_SCAN;
      end
      ST_SCAN: begin
        if (mask_q[d_q]) begin
          // Strict compare keeps the earliest run on ties.
          if (run_len > best_len_q) begin
            best_len_d   = run_len;
            best_start_d = run_start;
            best_slip_d  = s_q;
          end
          cur_len_d   = run_len;
          cur_start_d = run_start;
        end else begin
          cur_len_d = '0;
        end
        if (d_q == 5'd31) begin
          state_d = ST_NEXT;
        end else begin
          d_d = d_q + 5'd1;
        end
      end
      ST_NEXT: begin
        if (s_q == LAST_SLIP) begin
          state_d = ST_RESULT;
        end else begin
          s_d     = s_q + 4'd1;
          state_d = ST_LOAD;
        end
      end
      ST_RESULT: begin
        delay_sel_d = {2'b00, centre};
        slip_sel_d  = {4'b0000, best_slip_q};
        lock_ok_d   = (best_len_q >= MIN_LEN);
        done_d      = 1'b1;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

`ifdef SERDES_EYE_WINDOW_EN
  logic [5:0] win_len_q;

  always_ff @(posedge px_clk or negedge px_reset_n) begin
    if (!px_reset_n) begin
      win_len_q <= '0;
    end else if (state_q == ST_RESULT) begin
      win_len_q <= best_len_q;
    end
  end

  assign window_len_out = win_len_q;
`endif

  assign busy_out      = (state_q != ST_IDLE);
  assign delay_sel_out = delay_sel_q;
  assign slip_sel_out  = slip_sel_q;
  assign lock_ok_out   = lock_ok_q;
  assign done_out      = done_q;

endmodule

// File: tb/tb_serdes_eye_select.sv
// tb/tb_serdes_eye_select.sv - randomized bench for serdes_eye_select against a run-length reference model
module tb_serdes_eye_select;

  localparam int NSLIP = 12;
  localparam int MINW  = 4;
  localparam int LAT   = NSLIP * 34 + 2;

  logic        px_clk;
  logic        px_reset_n;
  logic [31:0] lock_mask_din;
  logic [3:0]  lock_mask_waddr;
  logic        lock_mask_we;
  logic        start;
  logic        busy_out;
  logic [7:0]  delay_sel_out;
  logic [7:0]  slip_sel_out;
  logic        lock_ok_out;
  logic        done_out;
`ifdef SERDES_EYE_WINDOW_EN
  logic [5:0]  window_len_out;
`endif

  int total;
  int bad;
  logic [31:0] tab [16];
  int e_delay, e_slip, e_ok, e_len;
  int p_delay, p_slip, p_ok, p_len;

  serdes_eye_select dut (
    .px_clk          (px_clk),
    .px_reset_n      (px_reset_n),
    .lock_mask_din   (lock_mask_din),
    .lock_mask_waddr (lock_mask_waddr),
    .lock_mask_we    (lock_mask_we),
    .start           (start),
    .busy_out        (busy_out),
    .delay_sel_out   (delay_sel_out),
    .slip_sel_out    (slip_sel_out),
    .lock_ok_out     (lock_ok_out),
    .done_out        (done_out)
`ifdef SERDES_EYE_WINDOW_EN
    ,
    .window_len_out  (window_len_out)
`endif
  );

  initial px_clk = 1'b0;
  always #5 px_clk = ~px_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Best window = longest stretch of consecutive ones from any start tap; first one wins on ties.
  task automatic model_eval();
    int best, bs, bsl, len;
    logic [31:0] m;
    best = 0; bs = 0; bsl = 0;
    for (int s = 0; s < NSLIP; s++) begin
      m = tab[s];
      for (int a = 0; a < 32; a++) begin
        len = 0;
        while ((a + len < 32) && m[a + len]) len++;
        if (len > best) begin
          best = len; bs = a; bsl = s;
        end
      end
    end
    e_delay = bs + best / 2;
    e_slip  = bsl;
    e_ok    = (best >= MINW) ? 1 : 0;
    e_len   = best;
  endtask

  task automatic write_entry(input int addr, input logic [31:0] din);
    @(negedge px_clk);
    lock_mask_we    = 1'b1;
    lock_mask_waddr = 4'(addr);
    lock_mask_din   = din;
    if (addr < NSLIP) tab[addr] = din;
    @(negedge px_clk);
    lock_mask_we = 1'b0;
  endtask

  task automatic clear_table();
    for (int i = 0; i < NSLIP; i++) write_entry(i, 32'h0);
  endtask

  function automatic logic [31:0] gen_mask();
    logic [63:0] t;
    int len, pos;
    case ($urandom_range(0, 4))
      0: return 32'h0;
      1: return $urandom;
      2: return $urandom & $urandom;
      default: begin
        len = $urandom_range(1, 32);
        pos = $urandom_range(0, 32 - len);
        t = ((64'd1 << len) - 64'd1) << pos;
        return t[31:0] | (($urandom_range(0, 1) == 1) ? ($urandom & $urandom & $urandom) : 32'h0);
      end
    endcase
  endfunction

  task automatic do_scan(input bit co_we, input logic [3:0] co_addr, input logic [31:0] co_din,
                         input int wr_at, input int st_at, input int rst_at);
    int cyc;
    int busy_err;
    bit hit_done;
    @(negedge px_clk);
    start           = 1'b1;
    lock_mask_we    = co_we;
    lock_mask_waddr = co_addr;
    lock_mask_din   = co_din;
    if (co_we && (co_addr < NSLIP)) tab[co_addr] = co_din;
    model_eval();
    @(negedge px_clk);
    start        = 1'b0;
    lock_mask_we = 1'b0;
    cyc = 1; busy_err = 0; hit_done = 1'b0;
    check("hold_delay", delay_sel_out, p_delay);
    check("hold_slip", slip_sel_out, p_slip);
    check("hold_ok", lock_ok_out, p_ok);
    check("busy_rise", busy_out, 1);
    forever begin
      if (done_out) begin
        hit_done = 1'b1;
        break;
      end
      if (cyc >= 1000) break;
      if (!busy_out) busy_err++;
      lock_mask_we = (cyc == wr_at);
      if (cyc == wr_at) begin
        lock_mask_waddr = 4'd4;
        lock_mask_din   = $urandom | 32'hFFFF_0000;
      end
      start = (cyc == st_at);
      if (cyc == rst_at) begin
        px_reset_n = 1'b0;
        #1;
        check("rst_busy", busy_out, 0);
        check("rst_delay", delay_sel_out, 0);
        check("rst_slip", slip_sel_out, 0);
        check("rst_ok", lock_ok_out, 0);
        check("rst_done", done_out, 0);
`ifdef SERDES_EYE_WINDOW_EN
        check("rst_win", window_len_out, 0);
`endif
        for (int i = 0; i < 16; i++) tab[i] = 32'h0;
        p_delay = 0; p_slip = 0; p_ok = 0; p_len = 0;
        start = 1'b0;
        lock_mask_we = 1'b0;
        repeat (3) @(negedge px_clk);
        px_reset_n = 1'b1;
        return;
      end
      @(negedge px_clk);
      cyc++;
    end
    lock_mask_we = 1'b0;
    start        = 1'b0;
    check("done_seen", hit_done, 1);
    check("latency", cyc, LAT);
    check("busy_during", busy_err, 0);
    check("busy_fall", busy_out, 0);
    check("delay_sel", delay_sel_out, e_delay);
    check("slip_sel", slip_sel_out, e_slip);
    check("lock_ok", lock_ok_out, e_ok);
`ifdef SERDES_EYE_WINDOW_EN
    check("window_len", window_len_out, e_len);
`endif
    @(negedge px_clk);
    check("done_pulse", done_out, 0);
    p_delay = e_delay; p_slip = e_slip; p_ok = e_ok; p_len = e_len;
  endtask

  initial begin
    total = 0; bad = 0;
    px_reset_n = 1'b0;
    start = 1'b0;
    lock_mask_we = 1'b0;
    lock_mask_waddr = '0;
    lock_mask_din = '0;
    for (int i = 0; i < 16; i++) tab[i] = 32'h0;
    p_delay = 0; p_slip = 0; p_ok = 0; p_len = 0;
    repeat (3) @(negedge px_clk);
    check("reset_busy", busy_out, 0);
    check("reset_delay", delay_sel_out, 0);
    check("reset_slip", slip_sel_out, 0);
    check("reset_ok", lock_ok_out, 0);
    check("reset_done", done_out, 0);
    px_reset_n = 1'b1;

    clear_table();
    write_entry(3, 32'h00FF0000);
    do_scan(1'b0, 4'd0, 32'h0, -1, -1, -1);
    check("tc1_delay", delay_sel_out, 20);
    check("tc1_slip", slip_sel_out, 3);
    check("tc1_ok", lock_ok_out, 1);

    clear_table();
    write_entry(2, 32'h000000F0);
    write_entry(7, 32'h0000F000);
    do_scan(1'b0, 4'd0, 32'h0, -1, -1, -1);
    check("tc2_delay", delay_sel_out, 6);
    check("tc2_slip", slip_sel_out, 2);

    clear_table();
    write_entry(0, 32'h00000007);
    do_scan(1'b0, 4'd0, 32'h0, -1, -1, -1);
    check("tc3_delay", delay_sel_out, 1);
    check("tc3_slip", slip_sel_out, 0);
    check("tc3_ok", lock_ok_out, 0);

    clear_table();
    write_entry(5, 32'h80000001);
    write_entry(11, 32'hFFFFFFFF);
    write_entry(13, 32'h0000FFFF);
    do_scan(1'b0, 4'd0, 32'h0, -1, -1, -1);
    check("tc4_delay", delay_sel_out, 16);
    check("tc4_slip", slip_sel_out, 11);

    do_scan(1'b0, 4'd0, 32'h0, 50, 200, -1);
    check("tc5_delay", delay_sel_out, 16);
    check("tc5_slip", slip_sel_out, 11);

    write_entry(1, 32'h00000FFF);
    do_scan(1'b0, 4'd0, 32'h0, -1, -1, 100);
    do_scan(1'b0, 4'd0, 32'h0, -1, -1, -1);
    check("tc6_ok", lock_ok_out, 0);

    for (int it = 0; it < 6; it++) begin
      for (int s = 0; s < NSLIP; s++) write_entry(s, gen_mask());
      write_entry($urandom_range(NSLIP, 15), 32'hFFFFFFFF);
      do_scan(1'b1, 4'($urandom_range(0, NSLIP - 1)), gen_mask(), -1, -1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
